// File: rtl/clk_en_gen_pkg.sv
// -----------------------------------------------------------------------------
// clk_en_gen_pkg
// Shared constants and types for the multi-channel clock-enable generator.
//   CNT_W_DEF      : default width of period registers and counters
//   RST_PERIOD_DEF : default period loaded at reset (1 Hz at 50 MHz)
//   sel_width()    : width of the channel-select bus, never below 1
//   period_t       : period/counter type at the default width
// -----------------------------------------------------------------------------
package clk_en_gen_pkg;

    localparam int          CNT_W_DEF      = 27;
    localparam int unsigned RST_PERIOD_DEF = 32'd49_999_999;

    typedef logic [CNT_W_DEF-1:0] period_t;

    // Channel-select width; a single channel still needs a 1-bit select.
    function automatic int sel_width(input int num_ch);
        if (num_ch > 1) begin
            return $clog2(num_ch);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/clk_en_chan.sv
// -----------------------------------------------------------------------------
// clk_en_chan
// One enable channel: up-counter, active and shadow period, pending-update
// flag and (with CLK_EN_GEN_SQUARE_EN defined) a divide-by-two toggle.
// Ports:
//   clk, rst     : clock, synchronous active-low reset
//   we, wdata    : period write into the shadow register
//   run          : counting enable (level)
//   realign      : zero the counter, commit the shadow period at once
//   clk_en       : registered one-cycle pulse every active_P+1 running cycles
//   busy_upd     : a written period is waiting for the next wrap
//   clk_sq       : registered square wave (only with CLK_EN_GEN_SQUARE_EN)
// -----------------------------------------------------------------------------
module clk_en_chan #(
    parameter int          CNT_W      = 27,
    parameter int unsigned RST_PERIOD = 32'd49_999_999
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [CNT_W-1:0] wdata,
    input  logic             run,
    input  logic             realign,
    output logic             clk_en,
    output logic             busy_upd
`ifdef CLK_EN_GEN_SQUARE_EN
    ,
    output logic             clk_sq
`endif
);

    localparam logic [CNT_W-1:0] RST_P = CNT_W'(RST_PERIOD);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] active_r;
    logic [CNT_W-1:0] shadow_r;
    logic             clk_en_r;
    logic             busy_r;
    logic             wrap_s;
    logic [CNT_W-1:0] commit_p_s;

    // Wrap detect and the period a realign commits (a same-cycle write wins).
    always_comb begin
        wrap_s     = (cnt_r == active_r);
        commit_p_s = shadow_r;
        if (we) begin
            commit_p_s = wdata;
        end else begin
            commit_p_s = shadow_r;
        end
    end

    // Counter, period registers, pulse and pending flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_r    <= '0;
            active_r <= RST_P;
            shadow_r <= RST_P;
            clk_en_r <= 1'b0;
            busy_r   <= 1'b0;
        end else if (realign) begin
            cnt_r    <= '0;
            active_r <= commit_p_s;
            shadow_r <= commit_p_s;
            clk_en_r <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            if (run) begin
                if (wrap_s) begin
                    cnt_r    <= '0;
                    clk_en_r <= 1'b1;
                    // Shadow equals active unless an update is pending.
                    active_r <= shadow_r;
                end else begin
                    cnt_r    <= cnt_r + ONE;
                    clk_en_r <= 1'b0;
                end
            end else begin
                clk_en_r <= 1'b0;
            end
            // A write on the wrap edge stays pending for the following wrap.
            if (we) begin
                shadow_r <= wdata;
                busy_r   <= 1'b1;
            end else if (run && wrap_s) begin
                busy_r   <= 1'b0;
            end else begin
                busy_r   <= busy_r;
            end
        end
    end

    assign clk_en   = clk_en_r;
    assign busy_upd = busy_r;

`ifdef CLK_EN_GEN_SQUARE_EN
    logic sq_r;

    // Toggle on the same edge that raises clk_en.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sq_r <= 1'b0;
        end else if (realign) begin
            sq_r <= 1'b0;
        end else if (run && wrap_s) begin
            sq_r <= ~sq_r;
        end else begin
            sq_r <= sq_r;
        end
    end

    assign clk_sq = sq_r;
`endif

endmodule

// File: rtl/clk_en_gen.sv
// -----------------------------------------------------------------------------
// clk_en_gen
// Multi-channel clock-enable generator: NUM_CH independent single-cycle
// enable pulses with run-time periods, per-channel run and global realign.
// No derived clocks are produced; all outputs are registered data.
// Optional feature macro: CLK_EN_GEN_SQUARE_EN adds clk_sq.
// Ports:
//   clk        : system clock (rising edge)
//   rst        : synchronous active-low reset
//   cfg_we     : period write strobe
//   cfg_sel    : target channel of the write (out-of-range index ignored)
//   cfg_period : new period P; channel pulses every P+1 cycles
//   run        : per-channel run enable
//   realign    : zero all counters and commit pending periods
//   clk_en     : per-channel enable pulses
//   busy_upd   : per-channel pending-update flags
//   clk_sq     : per-channel square waves (CLK_EN_GEN_SQUARE_EN only)
// -----------------------------------------------------------------------------
module clk_en_gen
    import clk_en_gen_pkg::*;
#(
    parameter int          NUM_CH     = 4,
    parameter int          CNT_W      = CNT_W_DEF,
    parameter int unsigned RST_PERIOD = RST_PERIOD_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_we,
    input  logic [sel_width(NUM_CH)-1:0] cfg_sel,
    input  logic [CNT_W-1:0]             cfg_period,
    input  logic [NUM_CH-1:0]            run,
    input  logic                         realign,
    output logic [NUM_CH-1:0]            clk_en,
    output logic [NUM_CH-1:0]            busy_upd
`ifdef CLK_EN_GEN_SQUARE_EN
    ,
    output logic [NUM_CH-1:0]            clk_sq
`endif
);

    localparam int SEL_W = sel_width(NUM_CH);

    logic [NUM_CH-1:0] we_s;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // Decode: an index with no matching channel writes nothing.
        assign we_s[i] = cfg_we & (cfg_sel == SEL_W'(i));

        clk_en_chan #(
            .CNT_W      (CNT_W),
            .RST_PERIOD (RST_PERIOD)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .we       (we_s[i]),
            .wdata    (cfg_period),
            .run      (run[i]),
            .realign  (realign),
            .clk_en   (clk_en[i]),
            .busy_upd (busy_upd[i])
`ifdef CLK_EN_GEN_SQUARE_EN
            ,
            .clk_sq   (clk_sq[i])
`endif
        );
    end

endmodule

// File: tb/tb_clk_en_gen.sv
// -----------------------------------------------------------------------------
// tb_clk_en_gen
// Randomized bench for clk_en_gen (3 channels, so select value 3 is out of
// range). The reference keeps, per channel, the number of running cycles left
// until the next pulse, plus the committed and pending periods.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_clk_en_gen;

    localparam int NCH  = 3;
    localparam int CW   = 8;
    localparam int RSTP = 4;

    logic          clk;
    logic          rst;
    logic          cfg_we;
    logic [1:0]    cfg_sel;
    logic [CW-1:0] cfg_period;
    logic [NCH-1:0] run;
    logic          realign;
    logic [NCH-1:0] clk_en;
    logic [NCH-1:0] busy_upd;
`ifdef CLK_EN_GEN_SQUARE_EN
    logic [NCH-1:0] clk_sq;
`endif

    clk_en_gen #(
        .NUM_CH     (NCH),
        .CNT_W      (CW),
        .RST_PERIOD (RSTP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_sel    (cfg_sel),
        .cfg_period (cfg_period),
        .run        (run),
        .realign    (realign),
        .clk_en     (clk_en),
        .busy_upd   (busy_upd)
`ifdef CLK_EN_GEN_SQUARE_EN
        ,
        .clk_sq     (clk_sq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference state per channel.
    int m_left [NCH];   // running cycles left before the next pulse
    int m_per  [NCH];   // committed period
    int m_next [NCH];   // period to adopt at the next pulse
    bit m_pend [NCH];
    bit m_en   [NCH];
    bit m_sq   [NCH];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance the reference by one clock edge given the inputs of that cycle.
    task automatic model_step();
        for (int c = 0; c < NCH; c++) begin
            bit wr;
            wr = cfg_we && (int'(cfg_sel) == c);
            if (!rst) begin
                m_left[c] = RSTP; m_per[c] = RSTP; m_next[c] = RSTP;
                m_pend[c] = 1'b0; m_en[c] = 1'b0; m_sq[c] = 1'b0;
            end else if (realign) begin
                if (wr) m_next[c] = int'(cfg_period);
                m_per[c]  = m_next[c];
                m_left[c] = m_per[c];
                m_pend[c] = 1'b0; m_en[c] = 1'b0; m_sq[c] = 1'b0;
            end else begin
                bit pulse;
                pulse = run[c] && (m_left[c] == 0);
                if (pulse) begin
                    m_per[c]  = m_next[c];
                    m_left[c] = m_per[c];
                    m_sq[c]   = ~m_sq[c];
                end else if (run[c]) begin
                    m_left[c] = m_left[c] - 1;
                end
                m_en[c] = pulse;
                if (wr) begin
                    m_next[c] = int'(cfg_period);
                    m_pend[c] = 1'b1;
                end else if (pulse) begin
                    m_pend[c] = 1'b0;
                end
            end
        end
    endtask

    task automatic compare_all(input int cyc);
        logic [NCH-1:0] e_en, e_busy, e_sq;
        for (int c = 0; c < NCH; c++) begin
            e_en[c] = m_en[c]; e_busy[c] = m_pend[c]; e_sq[c] = m_sq[c];
        end
        check_eq($sformatf("clk_en@%0d", cyc), 32'(clk_en), 32'(e_en));
        check_eq($sformatf("busy_upd@%0d", cyc), 32'(busy_upd), 32'(e_busy));
`ifdef CLK_EN_GEN_SQUARE_EN
        check_eq($sformatf("clk_sq@%0d", cyc), 32'(clk_sq), 32'(e_sq));
`else
        if (e_sq != e_sq) check_eq("unused", 32'd0, 32'd1);
`endif
    endtask

    initial begin
        rst = 1'b0; cfg_we = 1'b0; cfg_sel = 2'd0; cfg_period = '0;
        run = '0; realign = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            m_left[c] = 0; m_per[c] = 0; m_next[c] = 0;
            m_pend[c] = 1'b0; m_en[c] = 1'b0; m_sq[c] = 1'b0;
        end

        // Two reset edges, then release with all channels running.
        repeat (2) begin
            @(negedge clk);
            model_step();
        end
        @(negedge clk);
        check_eq("reset_clk_en", 32'(clk_en), 32'd0);
        check_eq("reset_busy", 32'(busy_upd), 32'd0);
        rst = 1'b1;
        run = '1;

        // Free-running phase: pulses land 5, 10, 15 edges after release.
        for (int k = 1; k <= 16; k++) begin
            model_step();
            @(negedge clk);
            compare_all(k);
            if (k == 4 || k == 5 || k == 10 || k == 15)
                check_eq($sformatf("fixed_pulse@%0d", k), 32'(clk_en),
                         (k == 4) ? 32'd0 : 32'h7);
        end

        // Randomized phase.
        for (int k = 17; k < 4000; k++) begin
            rst        = ($urandom_range(0, 199) != 0);
            cfg_we     = ($urandom_range(0, 7) == 0);
            cfg_sel    = 2'($urandom_range(0, 3));
            cfg_period = CW'($urandom_range(0, 6));
            realign    = ($urandom_range(0, 39) == 0);
            for (int c = 0; c < NCH; c++) run[c] = ($urandom_range(0, 7) != 0);
            model_step();
            @(negedge clk);
            compare_all(k);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
